// File: rtl/spi_tx_burst_ctrl.sv
// spi_tx_burst_ctrl
//   SPI master transmitter (CPHA=0) with an integrated TX FIFO that carries a
//   per-entry D/C flag. Queued words are streamed back-to-back inside a single
//   CS frame, so the bus side only needs to push words.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   enable                  allow frames to start / continue at word boundaries
//   cpol, prescaler         SCL idle level and divider (half-period = prescaler+1 clk),
//                           sampled in IDLE and held for the whole frame
//   flush                   empty the FIFO (only acted on in IDLE)
//   wr_valid/wr_ready       push handshake; wr_data/wr_dc = word and its D/C flag
//   fifo_level              entries currently held
//   cs_n, dc, scl, sda      SPI pins
//   word_done               1-clk pulse per completed word
//   busy                    frame in progress (state != IDLE)
//
// Configuration
//   SPI_TX_LSB_FIRST_EN     defined: LSB first; undefined: MSB first. Timing is identical.
module spi_tx_burst_ctrl #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PRESC_W    = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          cpol,
  input  logic [PRESC_W-1:0]            prescaler,
  input  logic                          flush,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          wr_dc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          cs_n,
  output logic                          dc,
  output logic                          scl,
  output logic                          sda,
  output logic                          word_done,
  output logic                          busy
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int BW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
`ifdef SPI_TX_LSB_FIRST_EN
  localparam int SB = 0;
`else
  localparam int SB = DATA_W - 1;
`endif

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t               state, state_n;
  logic                 pop;

  // ---------------- FIFO ----------------
  logic [DATA_W:0]      mem [FIFO_DEPTH];     // {dc, data}
  logic [AW:0]          wr_ptr, rd_ptr;       // extra MSB distinguishes full from empty
  logic [LVL_W-1:0]     level;
  logic                 full, flush_eff, push;
  logic [DATA_W:0]      head;

  assign level     = wr_ptr - rd_ptr;
  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign flush_eff = flush && (state == IDLE);
  assign push      = wr_valid && !full && !flush_eff;
  assign head      = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {wr_dc, wr_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_eff) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------- datapath regs ----------------
  logic [PRESC_W-1:0]   presc_q, cnt;
  logic                 cpol_q;
  logic                 half;                 // 0: first half of bit, 1: second half
  logic [BW-1:0]        bit_cnt;
  logic [DATA_W-1:0]    shreg;
  logic                 dc_q;
  logic                 tick, last_bit;

  assign tick     = (cnt == '0);
  assign last_bit = (bit_cnt == LAST_BIT);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        // flush takes priority over starting a frame in the same cycle
        if (enable && (level != '0) && !flush) begin
          state_n = SETUP;
          pop     = 1'b1;
        end
      end
      SETUP: if (tick) state_n = SHIFT;
      SHIFT: begin
        if (tick && half && last_bit) begin
          if (enable && (level != '0)) pop = 1'b1;
          else                         state_n = HOLD;
        end
      end
      HOLD: if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The SETUP half-period doubles as the first (scl=cpol) half of bit 0, so
  // SHIFT is entered at bit 0's second half. This places the first SCL edge
  // one half-period after cs_n falls and keeps the word at exactly
  // 2*DATA_W half-periods.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= '0;
      cpol_q    <= 1'b0;
      cnt       <= '0;
      half      <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      dc_q      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (state == IDLE) begin
        presc_q <= prescaler;
        cpol_q  <= cpol;
        cnt     <= prescaler;
        half    <= 1'b0;
        bit_cnt <= '0;
        if (pop) begin
          shreg <= head[DATA_W-1:0];
          dc_q  <= head[DATA_W];
        end
      end else begin
        cnt <= tick ? presc_q : cnt - PRESC_W'(1);
        if (tick) begin
          case (state)
            SETUP: half <= 1'b1;
            SHIFT: begin
              if (!half) begin
                half <= 1'b1;
              end else begin
                half <= 1'b0;
                if (last_bit) begin
                  word_done <= 1'b1;
                  bit_cnt   <= '0;
                  if (pop) begin
                    shreg <= head[DATA_W-1:0];
                    dc_q  <= head[DATA_W];
                  end
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
`ifdef SPI_TX_LSB_FIRST_EN
                  shreg   <= {1'b0, shreg[DATA_W-1:1]};
`else
                  shreg   <= {shreg[DATA_W-2:0], 1'b0};
`endif
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- outputs ----------------
  // In IDLE scl follows the live cpol so the idle level is right even in reset.
  assign scl        = (state == IDLE) ? cpol :
                      ((state == SHIFT) && half) ? ~cpol_q : cpol_q;
  assign sda        = ((state == SETUP) || (state == SHIFT)) ? shreg[SB] : 1'b0;
  assign cs_n       = (state == IDLE);
  assign busy       = (state != IDLE);
  assign dc         = dc_q;
  assign wr_ready   = !full;
  assign fifo_level = level;

endmodule

// File: tb/tb_spi_tx_burst_ctrl.sv
// Directed testbench for spi_tx_burst_ctrl (DATA_W=8, FIFO_DEPTH=16, PRESC_W=8).
module tb_spi_tx_burst_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable, cpol, flush, wr_valid, wr_dc;
  logic [7:0] prescaler, wr_data;
  logic       wr_ready, cs_n, dc, scl, sda, word_done, busy;
  logic [4:0] fifo_level;

  int checks = 0;
  int errors = 0;

  spi_tx_burst_ctrl #(.DATA_W(8), .FIFO_DEPTH(16), .PRESC_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cpol(cpol),
    .prescaler(prescaler), .flush(flush), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .wr_dc(wr_dc),
    .fifo_level(fifo_level), .cs_n(cs_n), .dc(dc), .scl(scl), .sda(sda),
    .word_done(word_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push(input logic [7:0] d, input logic c);
    @(negedge clk);
    wr_valid = 1'b1; wr_data = d; wr_dc = c;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Records one CS frame, sampling at negedges. Bits/dc are taken at each
  // leading SCL edge (idle -> active level).
  task automatic capture(input logic cp, input int budget,
                         output logic [63:0] bits, output logic [63:0] dcb,
                         output int nb, output int wd, output int csl,
                         output int gap, output int fe, output bit to);
    int n; logic prev; int last_e;
    bits = '0; dcb = '0; nb = 0; wd = 0; csl = 0; gap = 0; fe = -1; to = 1'b0;
    n = 0; last_e = -1;
    do begin @(negedge clk); n++; end while (cs_n !== 1'b0 && n < budget);
    if (cs_n !== 1'b0) begin to = 1'b1; return; end
    prev = cp;
    while (cs_n === 1'b0 && csl < budget) begin
      if (prev === cp && scl === ~cp) begin
        bits = {bits[62:0], sda}; dcb = {dcb[62:0], dc}; nb++;
        if (fe < 0) fe = csl;
        if (last_e >= 0 && csl - last_e > gap) gap = csl - last_e;
        last_e = csl;
      end
      if (word_done === 1'b1) wd++;
      prev = scl; csl++;
      @(negedge clk);
    end
    if (cs_n === 1'b0) to = 1'b1;
  endtask

  task automatic test_reset;
    checks++; if ({cs_n, scl, busy, sda, dc, word_done, fifo_level} !== {3'b100, 3'b000, 5'd0}) begin
      errors++; $display("FAIL reset_hold got cs/scl/busy/sda/dc/wd/lvl=%b%b%b%b%b%b/%0d want 100000/0",
                         cs_n, scl, busy, sda, dc, word_done, fifo_level); end
    @(negedge clk); reset_n = 1'b1;
    prescaler = 8'd3; cpol = 1'b0; enable = 1'b1;
    push(8'h5A, 1'b1);
    push(8'h33, 1'b0);
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1 || dc !== 1'b1) begin
      errors++; $display("FAIL reset_preframe busy=%b dc=%b want 1 1", busy, dc); end
    reset_n = 1'b0;
    #1;
    checks++; if ({cs_n, scl, busy, sda, dc, word_done} !== 6'b100000) begin
      errors++; $display("FAIL reset_midword got cs/scl/busy/sda/dc/wd=%b%b%b%b%b%b want 100000",
                         cs_n, scl, busy, sda, dc, word_done); end
    checks++; if (fifo_level !== 5'd0) begin
      errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({cs_n, scl, busy, fifo_level} !== {3'b100, 5'd0}) begin
      errors++; $display("FAIL reset_release cs/scl/busy=%b%b%b lvl=%0d want 100/0", cs_n, scl, busy, fifo_level); end
  endtask

  task automatic test_single_word;
    logic [63:0] b, d; int nb, wd, csl, gap, fe; bit to;
    enable = 1'b0; prescaler = 8'd0; cpol = 1'b0;
    push(8'hA5, 1'b0);
    enable = 1'b1;
    capture(1'b0, 200, b, d, nb, wd, csl, gap, fe, to);
    checks++; if (to) begin errors++; $display("FAIL single_timeout frame not seen/ended"); end
    checks++; if (nb !== 8 || b[7:0] !== 8'hA5) begin
      errors++; $display("FAIL single_bits got %0d bits %h want 8 bits a5", nb, b[7:0]); end
    checks++; if (d[7:0] !== 8'h00) begin errors++; $display("FAIL single_dc got %h want 00", d[7:0]); end
    checks++; if (wd !== 1) begin errors++; $display("FAIL single_word_done got %0d want 1", wd); end
    checks++; if (csl !== 17) begin errors++; $display("FAIL single_cs_low got %0d want 17", csl); end
    checks++; if (fe !== 1) begin errors++; $display("FAIL single_first_edge got %0d want 1", fe); end
    checks++; if (busy !== 1'b0 || scl !== 1'b0 || word_done !== 1'b0) begin
      errors++; $display("FAIL single_after busy=%b scl=%b wd=%b want 0 0 0", busy, scl, word_done); end
  endtask

  task automatic test_burst;
    logic [63:0] b, d; int nb, wd, csl, gap, fe; bit to;
    enable = 1'b0; prescaler = 8'd0; cpol = 1'b0;
    push(8'h2A, 1'b0); push(8'h11, 1'b1); push(8'h22, 1'b1);
    checks++; if (fifo_level !== 5'd3) begin errors++; $display("FAIL burst_level got %0d want 3", fifo_level); end
    enable = 1'b1;
    capture(1'b0, 300, b, d, nb, wd, csl, gap, fe, to);
    checks++; if (to) begin errors++; $display("FAIL burst_timeout frame not seen/ended"); end
    checks++; if (nb !== 24 || b[23:0] !== 24'h2A1122) begin
      errors++; $display("FAIL burst_bits got %0d bits %h want 24 bits 2a1122", nb, b[23:0]); end
    checks++; if (d[23:0] !== 24'h00FFFF) begin errors++; $display("FAIL burst_dc got %h want 00ffff", d[23:0]); end
    checks++; if (wd !== 3) begin errors++; $display("FAIL burst_word_done got %0d want 3", wd); end
    checks++; if (gap !== 2 || csl !== 49) begin
      errors++; $display("FAIL burst_timing gap=%0d cs_low=%0d want 2 49", gap, csl); end
    repeat (3) @(negedge clk);
    checks++; if (cs_n !== 1'b1 || fifo_level !== 5'd0) begin
      errors++; $display("FAIL burst_after cs_n=%b lvl=%0d want 1 0", cs_n, fifo_level); end
  endtask

  task automatic test_fifo_full;
    enable = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push(8'(i), 1'b0);
      if (i == 14) begin
        checks++; if (wr_ready !== 1'b1 || fifo_level !== 5'd15) begin
          errors++; $display("FAIL full_15 ready=%b lvl=%0d want 1 15", wr_ready, fifo_level); end
      end
    end
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_level got %0d want 16", fifo_level); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", wr_ready); end
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checks++; if (fifo_level !== 5'd0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL full_flush lvl=%0d ready=%b want 0 1", fifo_level, wr_ready); end
    push(8'h77, 1'b0);
    @(negedge clk); flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h88;
    @(negedge clk); flush = 1'b0; wr_valid = 1'b0;
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL flush_vs_push lvl=%0d want 0", fifo_level); end
  endtask

  task automatic test_enable_drop;
    logic [63:0] b, d; int nb, wd, csl, gap, fe; bit to;
    enable = 1'b0; prescaler = 8'd1; cpol = 1'b0;
    push(8'hC3, 1'b1); push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0);
    fork
      capture(1'b0, 300, b, d, nb, wd, csl, gap, fe, to);
      begin
        @(negedge clk); enable = 1'b1;
        repeat (8) @(negedge clk); enable = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
      end
    join
    checks++; if (to) begin errors++; $display("FAIL drop_timeout frame not seen/ended"); end
    checks++; if (nb !== 8 || b[7:0] !== 8'hC3 || wd !== 1) begin
      errors++; $display("FAIL drop_word got %0d bits %h wd=%0d want 8 c3 1", nb, b[7:0], wd); end
    checks++; if (csl !== 34 || fe !== 2) begin
      errors++; $display("FAIL drop_timing cs_low=%0d first_edge=%0d want 34 2", csl, fe); end
    checks++; if (fifo_level !== 5'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL drop_level lvl=%0d busy=%b want 3 0", fifo_level, busy); end
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL drop_flush lvl=%0d want 0", fifo_level); end
  endtask

  task automatic test_cpol1;
    logic [63:0] b, d; int nb, wd, csl, gap, fe; bit to;
    logic [7:0] exp_bits;
`ifdef SPI_TX_LSB_FIRST_EN
    exp_bits = 8'h80;
`else
    exp_bits = 8'h01;
`endif
    enable = 1'b0; prescaler = 8'd0; cpol = 1'b1;
    @(negedge clk);
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL cpol1_idle scl=%b want 1", scl); end
    push(8'h01, 1'b1);
    enable = 1'b1;
    capture(1'b1, 200, b, d, nb, wd, csl, gap, fe, to);
    checks++; if (to) begin errors++; $display("FAIL cpol1_timeout frame not seen/ended"); end
    checks++; if (nb !== 8 || b[7:0] !== exp_bits || d[7:0] !== 8'hFF) begin
      errors++; $display("FAIL cpol1_bits got %0d bits %h dc %h want 8 %h ff", nb, b[7:0], d[7:0], exp_bits); end
    checks++; if (scl !== 1'b1 || csl !== 17) begin
      errors++; $display("FAIL cpol1_after scl=%b cs_low=%0d want 1 17", scl, csl); end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; cpol = 1'b0; flush = 1'b0;
    wr_valid = 1'b0; wr_dc = 1'b0; prescaler = 8'd0; wr_data = 8'd0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_word();
    test_burst();
    test_fifo_full();
    test_enable_drop();
    test_cpol1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
